// File: rtl/alu_pkg.sv
// Shared encodings for alu_pipe: op select codes, FSM state codes and flag bit positions.
// The optional iterative divider is enabled by defining ALU_DIV_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL1 = 4'h4;
  localparam logic [3:0] OP_SHR1 = 4'h5;
  localparam logic [3:0] OP_ROL1 = 4'h6;
  localparam logic [3:0] OP_ROR1 = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_DZ    = 4;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiplier and (with ALU_DIV_EN) restoring divider, WIDTH steps.
// lo_o/hi_o carry the post-step values so the caller can register the result on the last step.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d, q_q, q_d, m_q;
  logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   trial;
`else
  logic             unused_div;
  assign unused_div = div_i;
`endif

  // p holds the running high half / remainder, q the multiplier / dividend-quotient
  always_comb begin
    sum = {1'b0, p_q} + (q_q[0] ? {1'b0, m_q} : '0);
    p_d = sum[WIDTH:1];
    q_d = {sum[0], q_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    trial = {p_q, q_q[WIDTH-1]};
    if (div_q) begin
      if (trial >= {1'b0, m_q}) begin
        p_d = WIDTH'(trial - {1'b0, m_q});
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d = trial[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = CNT_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_ONE;
  end

  assign done_o = (cnt_q == CNT_ONE);
  assign lo_o   = q_d;
  assign hi_o   = p_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      p_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (start_i) begin
        p_q <= '0;
        q_q <= a_i;
        m_q <= b_i;
`ifdef ALU_DIV_EN
        div_q <= div_i;
`endif
      end else if (cnt_q != '0) begin
        p_q <= p_d;
        q_q <= q_d;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU. MUL (and DIV when ALU_DIV_EN is defined) run in
// alu_seq_muldiv over WIDTH cycles; every other op completes in a single cycle.
//
// state   | meaning
// ST_IDLE | empty, accepting a new op
// ST_BUSY | iterative MUL/DIV in flight, inputs blocked
// ST_DONE | result on outputs, held until out_ready
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       flags
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [4:0]       fl_q, fl_d;
  logic             accept, multi, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi, c_lo;
  logic [WIDTH:0]   sum, dif;
  logic             carry, ovf, dz;
  logic [4:0]       c_fl, e_fl;
`ifdef ALU_DIV_EN
  logic             is_div_q, bz_q;
`endif

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign res_lo    = lo_q;
  assign res_hi    = hi_q;
  assign flags     = fl_q;

`ifdef ALU_DIV_EN
  assign multi = (op_i == OP_MUL) || (op_i == OP_DIV);
`else
  assign multi = (op_i == OP_MUL);
`endif

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && multi),
    .div_i   (op_i == OP_DIV),
    .a_i     (a_i),
    .b_i     (b_i),
    .done_o  (eng_done),
    .lo_o    (eng_lo),
    .hi_o    (eng_hi)
  );

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    dif   = {1'b0, a_i} - {1'b0, b_i};
    c_lo  = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    dz    = 1'b0;
    case (op_i)
      OP_ADD: begin
        c_lo  = sum[MSB:0];
        carry = sum[WIDTH];
        ovf   = (a_i[MSB] == b_i[MSB]) && (c_lo[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        c_lo  = dif[MSB:0];
        carry = dif[WIDTH];
        ovf   = (a_i[MSB] != b_i[MSB]) && (c_lo[MSB] != a_i[MSB]);
      end
      // only reached as a single-cycle op when the divider is not built
      OP_DIV:  dz = 1'b1;
      OP_SHL1: begin c_lo = {a_i[MSB-1:0], 1'b0}; carry = a_i[MSB]; end
      OP_SHR1: begin c_lo = {1'b0, a_i[MSB:1]};   carry = a_i[0];   end
      OP_ROL1: c_lo = {a_i[MSB-1:0], a_i[MSB]};
      OP_ROR1: c_lo = {a_i[0], a_i[MSB:1]};
      OP_AND:  c_lo = a_i & b_i;
      OP_OR:   c_lo = a_i | b_i;
      OP_XOR:  c_lo = a_i ^ b_i;
      OP_NOR:  c_lo = ~(a_i | b_i);
      OP_NAND: c_lo = ~(a_i & b_i);
      OP_XNOR: c_lo = ~(a_i ^ b_i);
      OP_GT:   c_lo = WIDTH'(a_i > b_i);
      OP_EQ:   c_lo = WIDTH'(a_i == b_i);
      default: ;
    endcase
    c_fl            = '0;
    c_fl[FLG_CARRY] = carry;
    c_fl[FLG_ZERO]  = (c_lo == '0);
    c_fl[FLG_NEG]   = c_lo[MSB];
    c_fl[FLG_OVF]   = ovf;
    c_fl[FLG_DZ]    = dz;
  end

  always_comb begin
    e_fl           = '0;
    e_fl[FLG_ZERO] = (eng_lo == '0);
    e_fl[FLG_NEG]  = eng_lo[MSB];
`ifdef ALU_DIV_EN
    e_fl[FLG_CARRY] = !is_div_q && (eng_hi != '0);
    e_fl[FLG_DZ]    = is_div_q && bz_q;
`else
    e_fl[FLG_CARRY] = (eng_hi != '0);
`endif
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    fl_d    = fl_q;
    if (accept) begin
      if (multi) begin
        state_d = ST_BUSY;
      end else begin
        state_d = ST_DONE;
        lo_d    = c_lo;
        hi_d    = '0;
        fl_d    = c_fl;
      end
    end else if ((state_q == ST_BUSY) && eng_done) begin
      state_d = ST_DONE;
      lo_d    = eng_lo;
      hi_d    = eng_hi;
      fl_d    = e_fl;
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      fl_q    <= '0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
      bz_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      fl_q    <= fl_d;
`ifdef ALU_DIV_EN
      if (accept) begin
        is_div_q <= (op_i == OP_DIV);
        bz_q     <= (b_i == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios plus randomized ops checked against an arithmetic
// reference model, on a WIDTH=8 instance and a WIDTH=2 instance.
module tb_alu_pipe;

  logic clk, rst_n;
  logic iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, lo8, hi8;
  logic [3:0] op8;
  logic [4:0] fl8;
  logic iv2, ir2, ov2, or2;
  logic [1:0] a2, b2, lo2, hi2;
  logic [3:0] op2;
  logic [4:0] fl2;
  int checks, errors;

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a_i(a8), .b_i(b8), .op_i(op8),
    .out_valid(ov8), .out_ready(or8), .res_lo(lo8), .res_hi(hi8), .flags(fl8));

  alu_pipe #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a_i(a2), .b_i(b2), .op_i(op2),
    .out_valid(ov2), .out_ready(or2), .res_lo(lo2), .res_hi(hi2), .flags(fl2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: flags index {dz=4, ovf=3, neg=2, zero=1, carry=0}
  function automatic void model(input int w, input logic [3:0] op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned lo,
                                output longint unsigned hi, output logic [4:0] fl, output int lat);
    longint unsigned mask, p;
    longint sa, sb, sr, smax, smin;
    mask = (64'd1 << w) - 1;
    smax = longint'(mask >> 1);
    smin = -smax - 1;
    sa = ((a >> (w - 1)) != 0) ? longint'(a) - longint'(mask) - 1 : longint'(a);
    sb = ((b >> (w - 1)) != 0) ? longint'(b) - longint'(mask) - 1 : longint'(b);
    lo = 0; hi = 0; fl = '0; lat = 1;
    case (op)
      4'h0: begin lo = (a + b) & mask; fl[0] = ((a + b) >> w) != 0;
                  sr = sa + sb; fl[3] = (sr > smax) || (sr < smin); end
      4'h1: begin lo = (a - b) & mask; fl[0] = a < b;
                  sr = sa - sb; fl[3] = (sr > smax) || (sr < smin); end
      4'h2: begin p = a * b; lo = p & mask; hi = p >> w; fl[0] = hi != 0; lat = w + 1; end
`ifdef ALU_DIV_EN
      4'h3: begin
        lat = w + 1;
        if (b == 0) begin lo = mask; hi = a; fl[4] = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
`else
      4'h3: fl[4] = 1'b1;
`endif
      4'h4: begin lo = (a << 1) & mask; fl[0] = (a >> (w - 1)) != 0; end
      4'h5: begin lo = a >> 1; fl[0] = (a & 1) != 0; end
      4'h6: lo = ((a << 1) | (a >> (w - 1))) & mask;
      4'h7: lo = (a >> 1) | ((a & 1) << (w - 1));
      4'h8: lo = a & b;
      4'h9: lo = a | b;
      4'hA: lo = a ^ b;
      4'hB: lo = ~(a | b) & mask;
      4'hC: lo = ~(a & b) & mask;
      4'hD: lo = ~(a ^ b) & mask;
      4'hE: lo = (a > b) ? 1 : 0;
      default: lo = (a == b) ? 1 : 0;
    endcase
    fl[1] = (lo == 0);
    fl[2] = ((lo >> (w - 1)) & 1) != 0;
  endfunction

  // Issue one op; lat = cycles from accept to out_valid (-1 on timeout), rdy = busy cycles with in_ready high
  task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int rdy);
    int n;
    lat = -1; rdy = 0; n = 0;
    while (!ir8 && n < 100) begin @(posedge clk); #1; n++; end
    if (!ir8) return;
    op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    n = 1;
    while (!ov8 && n < 100) begin if (ir8) rdy++; @(posedge clk); #1; n++; end
    if (ov8) lat = n;
  endtask

  task automatic do_op2(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                        output int lat);
    int n;
    lat = -1; n = 0;
    while (!ir2 && n < 100) begin @(posedge clk); #1; n++; end
    if (!ir2) return;
    op2 = op; a2 = a; b2 = b; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0; op2 = 4'($urandom); a2 = 2'($urandom); b2 = 2'($urandom);
    n = 1;
    while (!ov2 && n < 100) begin @(posedge clk); #1; n++; end
    if (ov2) lat = n;
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8 got %b want 1", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got %b want 0", ov8); end
    checks++; if ({lo8, hi8, fl8} !== 21'h0) begin errors++; $display("FAIL reset_outs8 got %h/%h/%b want 0", lo8, hi8, fl8); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready2 got %b want 1", ir2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got %b want 0", ov2); end
    checks++; if ({lo2, hi2, fl2} !== 9'h0) begin errors++; $display("FAIL reset_outs2 got %h/%h/%b want 0", lo2, hi2, fl2); end
  endtask

  task automatic test_reset_mid_busy();
    int lat, rdy, seen;
    op8 = 4'h2; a8 = 8'h05; b8 = 8'h06; iv8 = 1'b1;
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", ov8); end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", ir8); end
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (ov8) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    do_op8(4'h0, 8'h02, 8'h03, lat, rdy);
    checks++; if (lat != 1) begin errors++; $display("FAIL abort_add_lat got %0d want 1", lat); end
    checks++; if (lo8 !== 8'h05) begin errors++; $display("FAIL abort_add_lo got %h want 05", lo8); end
  endtask

  task automatic test_add();
    int lat, rdy;
    do_op8(4'h0, 8'hFF, 8'h01, lat, rdy);
    checks++; if (lat != 1) begin errors++; $display("FAIL add_ff_lat got %0d want 1", lat); end
    checks++; if (lo8 !== 8'h00) begin errors++; $display("FAIL add_ff_lo got %h want 00", lo8); end
    checks++; if (fl8 !== 5'b00011) begin errors++; $display("FAIL add_ff_flags got %b want 00011", fl8); end
    do_op8(4'h0, 8'h7F, 8'h01, lat, rdy);
    checks++; if (lo8 !== 8'h80) begin errors++; $display("FAIL add_7f_lo got %h want 80", lo8); end
    checks++; if (fl8 !== 5'b01100) begin errors++; $display("FAIL add_7f_flags got %b want 01100", fl8); end
  endtask

  task automatic test_mul();
    int lat, rdy;
    do_op8(4'h2, 8'h10, 8'h20, lat, rdy);
    checks++; if (lat != 9) begin errors++; $display("FAIL mul_lat got %0d want 9", lat); end
    checks++; if (rdy != 0) begin errors++; $display("FAIL mul_busy_ready got %0d cycles want 0", rdy); end
    checks++; if ({hi8, lo8} !== 16'h0200) begin errors++; $display("FAIL mul_res got %h%h want 0200", hi8, lo8); end
    checks++; if (fl8 !== 5'b00011) begin errors++; $display("FAIL mul_flags got %b want 00011", fl8); end
  endtask

  task automatic test_div();
    int lat, rdy;
`ifdef ALU_DIV_EN
    do_op8(4'h3, 8'd100, 8'd7, lat, rdy);
    checks++; if (lat != 9) begin errors++; $display("FAIL div_lat got %0d want 9", lat); end
    checks++; if ({hi8, lo8} !== 16'h020E) begin errors++; $display("FAIL div_res got %h/%h want 02/0E", hi8, lo8); end
    checks++; if (fl8 !== 5'b00000) begin errors++; $display("FAIL div_flags got %b want 00000", fl8); end
    do_op8(4'h3, 8'h0A, 8'h00, lat, rdy);
    checks++; if (lat != 9) begin errors++; $display("FAIL divz_lat got %0d want 9", lat); end
    checks++; if ({hi8, lo8} !== 16'h0AFF) begin errors++; $display("FAIL divz_res got %h/%h want 0A/FF", hi8, lo8); end
    checks++; if (fl8 !== 5'b10100) begin errors++; $display("FAIL divz_flags got %b want 10100", fl8); end
`else
    do_op8(4'h3, 8'd100, 8'd7, lat, rdy);
    checks++; if (lat != 1) begin errors++; $display("FAIL nodiv_lat got %0d want 1", lat); end
    checks++; if ({hi8, lo8} !== 16'h0000) begin errors++; $display("FAIL nodiv_res got %h/%h want 00/00", hi8, lo8); end
    checks++; if (fl8 !== 5'b10010) begin errors++; $display("FAIL nodiv_flags got %b want 10010", fl8); end
`endif
  endtask

  task automatic test_backpressure();
    int lat, rdy;
    do_op8(4'h8, 8'hF0, 8'h3C, lat, rdy);
    or8 = 1'b0;
    checks++; if (lo8 !== 8'h30) begin errors++; $display("FAIL and_lo got %h want 30", lo8); end
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if ({ov8, ir8, lo8, hi8, fl8} !== {1'b1, 1'b0, 8'h30, 8'h00, 5'b0}) begin
        errors++; $display("FAIL hold got v%b r%b %h/%h/%b want v1 r0 30/00/00000", ov8, ir8, lo8, hi8, fl8); end
    end
    or8 = 1'b1; op8 = 4'hA; a8 = 8'h55; b8 = 8'h0F; iv8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ir8); end
    @(posedge clk); #1; iv8 = 1'b0;
    checks++; if ({ov8, lo8} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL xor_next got v%b %h want v1 5A", ov8, lo8); end
  endtask

  task automatic test_random();
    int lat, rdy, elat, k;
    logic [3:0] op;
    logic [7:0] a, b;
    longint unsigned elo, ehi;
    logic [4:0] efl;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom); a = pick8(); b = pick8();
      model(8, op, longint'(a), longint'(b), elo, ehi, efl, elat);
      do_op8(op, a, b, lat, rdy);
      checks++; if (lat != elat || rdy != 0) begin errors++; $display("FAIL rnd_timing op %h got lat %0d rdy %0d want %0d 0", op, lat, rdy, elat); end
      checks++; if ({hi8, lo8, fl8} !== {8'(ehi), 8'(elo), efl}) begin
        errors++; $display("FAIL rnd_res op %h a %h b %h got %h/%h/%b want %h/%h/%b", op, a, b, hi8, lo8, fl8, 8'(ehi), 8'(elo), efl); end
      if ($urandom_range(0, 3) == 0) begin
        or8 = 1'b0;
        k = $urandom_range(1, 3);
        repeat (k) begin
          @(posedge clk); #1;
          checks++; if ({ov8, lo8, hi8} !== {1'b1, 8'(elo), 8'(ehi)}) begin
            errors++; $display("FAIL rnd_hold got v%b %h/%h want v1 %h/%h", ov8, lo8, hi8, 8'(elo), 8'(ehi)); end
        end
        or8 = 1'b1;
      end
    end
  endtask

  task automatic test_w2_sweep();
    int lat, elat;
    longint unsigned elo, ehi;
    logic [4:0] efl;
    logic [3:0] op;
    logic [1:0] a, b;
    for (int pass = 0; pass < 17; pass++) begin
      for (int o = 0; o < 16; o++) begin
        op = 4'(o);
        a = (pass == 0) ? 2'd3 : 2'(pass - 1);
        b = (pass == 0) ? 2'd1 : 2'((pass - 1) >> 2);
        model(2, op, longint'(a), longint'(b), elo, ehi, efl, elat);
        do_op2(op, a, b, lat);
        checks++; if (lat != elat) begin errors++; $display("FAIL w2_lat op %h got %0d want %0d", op, lat, elat); end
        checks++; if ({hi2, lo2, fl2} !== {2'(ehi), 2'(elo), efl}) begin
          errors++; $display("FAIL w2_res op %h a %h b %h got %h/%h/%b want %h/%h/%b", op, a, b, hi2, lo2, fl2, 2'(ehi), 2'(elo), efl); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
    iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    test_reset();
    test_reset_mid_busy();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_random();
    test_w2_sweep();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
